multi_channel_serializer: RTL

MULTI_CHANNEL_SERIALIZER -- requirements
Module: multi_channel_serializer

---
 rtl/serializer_pkg.sv | 16 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/multi_channel_serializer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared types and default parameters for the multi-channel serializer.
package serializer_pkg;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_N_CH       = 2;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam bit          DEF_MSB_FIRST  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO of sample sets; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    // Storage write; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                level <= level + LVL_W'(1);
            end else if (pop_ok && !push_ok) begin
                level <= level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/multi_channel_serializer.sv
// Buffers filtered sample sets and streams each one as a mode-0 serial frame
// (channel 0 first) with a chip select framing every set.
module multi_channel_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned N_CH       = DEF_N_CH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter bit          MSB_FIRST  = DEF_MSB_FIRST
) (
    input  logic                          rp2350_sck,
    input  logic                          rst,
    input  logic [N_CH*DATA_W-1:0]        filtered_data,
    input  logic                          filter_done,
    output logic                          rpi_mosi,
    output logic                          rpi_cs,
    output logic                          rpi_sck,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned FRAME_W = N_CH * DATA_W;
    localparam int unsigned CNT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    logic [1:0]         rst_sync;
    logic               rst_i;
    state_t             state;
    logic               phase;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] load_frame;
    logic [FRAME_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    // Reset asserts immediately and releases two clock edges later.
    always_ff @(posedge rp2350_sck or posedge rst) begin
        if (rst) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end

    assign rst_i = rst_sync[1];
    assign pop   = (state == IDLE) && !fifo_empty;

    sync_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (rp2350_sck),
        .rst   (rst_i),
        .push  (filter_done),
        .wdata (filtered_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Reorder the head set so the frame always leaves from its top bit.
    always_comb begin
        load_frame = '0;
        for (int ch = 0; ch < int'(N_CH); ch++) begin
            for (int b = 0; b < int'(DATA_W); b++) begin
                load_frame[int'(FRAME_W) - 1 - (ch * int'(DATA_W) + b)] =
                    MSB_FIRST ? head[ch * int'(DATA_W) + int'(DATA_W) - 1 - b]
                              : head[ch * int'(DATA_W) + b];
            end
        end
    end

    // Sticky drop flag: a strobe into a full FIFO that is not popping this cycle.
    always_ff @(posedge rp2350_sck or posedge rst_i) begin
        if (rst_i) begin
            overflow <= 1'b0;
        end else if (filter_done && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // Frame FSM; each state's pins are registered on the edge it executes.
    always_ff @(posedge rp2350_sck or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            phase    <= 1'b0;
            bit_cnt  <= '0;
            frame    <= '0;
            rpi_cs   <= 1'b1;
            rpi_sck  <= 1'b0;
            rpi_mosi <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rpi_cs   <= 1'b1;
                    rpi_sck  <= 1'b0;
                    rpi_mosi <= 1'b1;
                    if (!fifo_empty) begin
                        frame <= load_frame;
                        state <= SETUP;
                        busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    rpi_cs   <= 1'b0;
                    rpi_sck  <= 1'b0;
                    rpi_mosi <= frame[FRAME_W-1];
                    phase    <= 1'b0;
                    bit_cnt  <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    rpi_sck <= phase;
                    phase   <= ~phase;
                    if (!phase) begin
                        rpi_mosi <= frame[FRAME_W-1];
                    end else if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                        state <= HOLD;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        frame   <= frame << 1;
                    end
                end
                HOLD: begin
                    rpi_cs  <= 1'b0;
                    rpi_sck <= 1'b0;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
